// File: rtl/csa_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : csa_stream_tx
//  Description : Buffers fixed-size CSA input records in a small FIFO and
//                serialises them onto an AXI4-Stream master as 32-bit beats.
//                A packet holds RECORDS_PER_PACKET records; a flush pulse
//                closes an open packet early at the end of the record in
//                flight.
//  Ports       : m00_axis_aclk / m00_axis_areset  clock, async active-high reset
//                rec_valid / rec_ready / rec_data record input handshake
//                flush                             close open packet early
//                m00_axis_t*                       AXIS master beat channel
//                pkt_count                         completed packets (mod 2^32)
//                busy                              FIFO non-empty or packet open
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_stream_tx #(
    parameter int RECORD_WORDS       = 5,
    parameter int RECORDS_PER_PACKET = 10,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                         m00_axis_aclk,
    input  logic                         m00_axis_areset,
    input  logic                         rec_valid,
    output logic                         rec_ready,
    input  logic [RECORD_WORDS*32-1:0]   rec_data,
    input  logic                         flush,
    output logic                         m00_axis_tvalid,
    output logic [31:0]                  m00_axis_tdata,
    output logic [3:0]                   m00_axis_tstrb,
    output logic                         m00_axis_tlast,
    input  logic                         m00_axis_tready,
    output logic [31:0]                  pkt_count,
    output logic                         busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WI_W  = (RECORD_WORDS > 1) ? $clog2(RECORD_WORDS) : 1;
    localparam int RC_W  = (RECORDS_PER_PACKET > 1) ? $clog2(RECORDS_PER_PACKET) : 1;
    localparam int REC_W = RECORD_WORDS * 32;

    localparam logic [WI_W-1:0]  c_LAST_WORD = WI_W'(RECORD_WORDS - 1);
    localparam logic [RC_W-1:0]  c_LAST_REC  = RC_W'(RECORDS_PER_PACKET - 1);
    localparam logic [CNT_W-1:0] c_DEPTH     = CNT_W'(FIFO_DEPTH);

    // Record storage; contents need no reset because occupancy gates all reads.
    logic [REC_W-1:0] r_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_rec_ready;
    logic             r_tvalid;
    logic             r_flush_pend;
    logic [WI_W-1:0]  r_word_idx;
    logic [RC_W-1:0]  r_rec_idx;
    logic [31:0]      r_pkt_count;

    logic             w_push;
    logic             w_beat;
    logic             w_last_word;
    logic             w_pop;
    logic             w_tlast;
    logic             w_pkt_open;
    logic [REC_W-1:0] w_head;
    logic [31:0]      w_word;

    assign w_push      = rec_valid & r_rec_ready;
    assign w_beat      = r_tvalid & m00_axis_tready;
    assign w_last_word = (r_word_idx == c_LAST_WORD);
    assign w_pop       = w_beat & w_last_word;
    assign w_tlast     = r_tvalid & w_last_word &
                         ((r_rec_idx == c_LAST_REC) | r_flush_pend);
    assign w_pkt_open  = (r_rec_idx != '0) | (r_word_idx != '0);

    // Push is impossible when full (rec_ready low) and pop is impossible when
    // empty (tvalid low), so the occupancy never over- or under-flows.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rec_data;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_word = '0;
        for (int k = 0; k < RECORD_WORDS; k++) begin
            if (r_word_idx == WI_W'(k)) begin
                w_word = w_head[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rec_ready  <= 1'b0;
            r_tvalid     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_word_idx   <= '0;
            r_rec_idx    <= '0;
            r_pkt_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            // Handshake flags are registered copies of the next occupancy so
            // they track the FIFO exactly without any input-to-output path.
            r_tvalid    <= (w_count_nxt != '0);
            r_rec_ready <= (w_count_nxt != c_DEPTH);

            if (w_beat) begin
                if (w_tlast) begin
                    r_word_idx   <= '0;
                    r_rec_idx    <= '0;
                    r_flush_pend <= 1'b0;
                    r_pkt_count  <= r_pkt_count + 32'd1;
                end else if (w_last_word) begin
                    r_word_idx <= '0;
                    r_rec_idx  <= r_rec_idx + 1'b1;
                end else begin
                    r_word_idx <= r_word_idx + 1'b1;
                end
            end

            // A flush coinciding with the closing tlast is absorbed by it;
            // a flush with no open packet is dropped.
            if (flush && w_pkt_open && !(w_beat && w_tlast)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign rec_ready       = r_rec_ready;
    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tdata  = r_tvalid ? w_word : 32'd0;
    assign m00_axis_tstrb  = 4'hF;
    assign m00_axis_tlast  = w_tlast;
    assign pkt_count       = r_pkt_count;
    assign busy            = (r_count != '0) | w_pkt_open;

endmodule
`default_nettype wire

// File: tb/tb_csa_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_stream_tx
//  Description : Directed self-checking bench for csa_stream_tx with the
//                default geometry (5 words/record, 10 records/packet, 4-deep
//                FIFO). Word k of record r carries (r << 8) | k.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_stream_tx;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rec_valid = 1'b0;
    logic         rec_ready;
    logic [159:0] rec_data = '0;
    logic         flush = 1'b0;
    logic         m00_axis_tvalid;
    logic [31:0]  m00_axis_tdata;
    logic [3:0]   m00_axis_tstrb;
    logic         m00_axis_tlast;
    logic         m00_axis_tready = 1'b0;
    logic [31:0]  pkt_count;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_sent = 0;
    int cyc = 0;
    logic [31:0] got_d[$];
    bit          got_l[$];
    int          got_c[$];

    always #5 clk = ~clk;

    csa_stream_tx #(
        .RECORD_WORDS       (5),
        .RECORDS_PER_PACKET (10),
        .FIFO_DEPTH         (4)
    ) u_dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (rst),
        .rec_valid       (rec_valid),
        .rec_ready       (rec_ready),
        .rec_data        (rec_data),
        .flush           (flush),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tstrb  (m00_axis_tstrb),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tready (m00_axis_tready),
        .pkt_count       (pkt_count),
        .busy            (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int r, input int k);
        return (32'(r) << 8) | 32'(k);
    endfunction

    function automatic logic [159:0] mkrec(input int r);
        logic [159:0] v;
        for (int k = 0; k < 5; k++) v[k*32 +: 32] = wd(r, k);
        return v;
    endfunction

    // Record the handshakes that the coming edge will complete, then advance.
    task automatic step();
        if (rec_valid && rec_ready) n_sent++;
        if (m00_axis_tvalid && m00_axis_tready) begin
            got_d.push_back(m00_axis_tdata);
            got_l.push_back(m00_axis_tlast);
            got_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        flush = 1'b0;
    endtask

    task automatic clear_beats();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    task automatic stream(input string tag, input int nrec, input int base, input bit rnd,
                          input int flush_beat, input int stop_beats);
        int target;
        target = (stop_beats > 0) ? stop_beats : nrec * 5;
        n_sent = 0;
        clear_beats();
        for (int c = 0; c < 20000; c++) begin
            if (got_d.size() >= target) break;
            rec_valid       = (n_sent < nrec);
            rec_data        = mkrec(base + n_sent);
            m00_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            flush = (flush_beat >= 0) && (got_d.size() == flush_beat) &&
                    m00_axis_tvalid && m00_axis_tready;
            step();
        end
        rec_valid = 1'b0;
        if (got_d.size() < target) check_val({tag, "_timeout"}, got_d.size(), target);
    endtask

    // Beat i belongs to record base+i/5, word i%5; tlast every 50th beat
    // plus at the index closed by a flush.
    task automatic check_beats(input string tag, input int base, input int flush_last);
        bit exp_l;
        for (int i = 0; i < got_d.size(); i++) begin
            exp_l = ((i % 50) == 49) || (i == flush_last);
            check_val($sformatf("%s_data%0d", tag, i), got_d[i], wd(base + i / 5, i % 5));
            check_val($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(exp_l));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rec_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
    endtask

    initial begin
        int stable;

        // ---------------- reset state ----------------
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_tvalid", 32'(m00_axis_tvalid), 32'd0);
        check_val("rst_tlast", 32'(m00_axis_tlast), 32'd0);
        check_val("rst_tdata", m00_axis_tdata, 32'd0);
        check_val("rst_tstrb", 32'(m00_axis_tstrb), 32'hF);
        check_val("rst_ready", 32'(rec_ready), 32'd0);
        check_val("rst_pkt", pkt_count, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        check_val("rel_ready_pre", 32'(rec_ready), 32'd0);
        step();
        check_val("rel_ready_post", 32'(rec_ready), 32'd1);

        // ---------------- one full packet, tready high ----------------
        stream("t1", 10, 0, 1'b0, -1, 0);
        check_val("t1_count", got_d.size(), 32'd50);
        check_beats("t1", 0, -1);
        check_val("t1_final", got_d[49], 32'h0000_0904);
        check_val("t1_consec", got_c[49] - got_c[0], 32'd49);
        check_val("t1_pkt", pkt_count, 32'd1);
        check_val("t1_busy", 32'(busy), 32'd0);

        // ---------------- back-pressure, FIFO fill ----------------
        do_reset();
        m00_axis_tready = 1'b0;
        n_sent = 0;
        clear_beats();
        for (int i = 0; i < 4; i++) begin
            rec_valid = 1'b1;
            rec_data  = mkrec(16 + i);
            check_val($sformatf("t2_ready%0d", i), 32'(rec_ready), 32'd1);
            step();
            if (i == 0) begin
                check_val("t2_lat_tvalid", 32'(m00_axis_tvalid), 32'd1);
                check_val("t2_lat_tdata", m00_axis_tdata, wd(16, 0));
            end
        end
        check_val("t2_full_ready", 32'(rec_ready), 32'd0);
        check_val("t2_busy", 32'(busy), 32'd1);
        rec_data = mkrec(20);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (m00_axis_tvalid && m00_axis_tdata == wd(16, 0) && !m00_axis_tlast &&
                m00_axis_tstrb == 4'hF) stable++;
            step();
        end
        check_val("t2_hold", stable, 32'd20);
        check_val("t2_accepted", n_sent, 32'd4);
        check_val("t2_still_full", 32'(rec_ready), 32'd0);
        rec_valid = 1'b0;
        m00_axis_tready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (got_d.size() >= 20) break;
            step();
        end
        check_val("t2_count", got_d.size(), 32'd20);
        check_beats("t2", 16, -1);
        check_val("t2_pkt", pkt_count, 32'd0);
        check_val("t2_open_busy", 32'(busy), 32'd1);
        check_val("t2_tvalid_end", 32'(m00_axis_tvalid), 32'd0);

        // ---------------- early flush ----------------
        do_reset();
        stream("t3", 3, 32, 1'b0, 11, 0);
        check_val("t3_count", got_d.size(), 32'd15);
        check_beats("t3", 32, 14);
        check_val("t3_pkt", pkt_count, 32'd1);
        check_val("t3_busy", 32'(busy), 32'd0);
        stream("t3b", 10, 35, 1'b0, -1, 0);
        check_beats("t3b", 35, -1);
        check_val("t3b_pkt", pkt_count, 32'd2);

        // ---------------- flush while idle ----------------
        m00_axis_tready = 1'b1;
        clear_beats();
        flush = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        check_val("t4_beats", got_d.size(), 32'd0);
        check_val("t4_tlast", 32'(m00_axis_tlast), 32'd0);
        check_val("t4_pkt", pkt_count, 32'd2);
        check_val("t4_busy", 32'(busy), 32'd0);
        stream("t4b", 10, 48, 1'b0, -1, 0);
        check_beats("t4b", 48, -1);
        check_val("t4b_pkt", pkt_count, 32'd3);

        // ---------------- random back-pressure, 30 packets ----------------
        do_reset();
        stream("t5", 300, 256, 1'b1, -1, 0);
        check_val("t5_count", got_d.size(), 32'd1500);
        check_beats("t5", 256, -1);
        check_val("t5_pkt", pkt_count, 32'd30);

        // ---------------- reset mid-packet ----------------
        stream("t6", 10, 80, 1'b0, -1, 24);
        check_val("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_val("t6_tvalid", 32'(m00_axis_tvalid), 32'd0);
        check_val("t6_tdata", m00_axis_tdata, 32'd0);
        check_val("t6_tlast", 32'(m00_axis_tlast), 32'd0);
        check_val("t6_ready", 32'(rec_ready), 32'd0);
        check_val("t6_busy", 32'(busy), 32'd0);
        check_val("t6_pkt", pkt_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check_val("t6_ready_rel", 32'(rec_ready), 32'd1);
        stream("t6b", 10, 96, 1'b0, -1, 0);
        check_beats("t6b", 96, -1);
        check_val("t6b_pkt", pkt_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
